countdown_timer_core: RTL and testbench

Parametrised successor to the fixed 150 s count-up ramen timer. Runnable countdown timer with start/pause/resume, runtime preset load, saturating mm:ss range and a blinking alarm. Sits between button pulse logic (already debounced, 1-cycle pulses) and the digit_decoder/7-seg display path. Emits BCD digits plus a 1 s tick for downstream display and LED logic.

---
 rtl/countdown_timer_core_if.sv | 25 ++
 rtl/countdown_timer_core.sv | 209 ++++++++++++++++++++
 tb/tb_countdown_timer_core.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_core_if.sv
// Command/status bundle for countdown_timer_core.
// The master side drives the command pulses. The slave side (the timer) drives the status.
interface countdown_timer_core_if;
  logic        start_stop;
  logic        load;
  logic [11:0] preset_s;
  logic [1:0]  state;
  logic [11:0] remaining_s;
  logic [15:0] bcd_digits;
  logic        tick_1s;
  logic        alarm;
  logic        alarm_blink;

  modport master (
    output start_stop, load, preset_s,
    input  state, remaining_s, bcd_digits,
    input  tick_1s, alarm, alarm_blink
  );

  modport slave (
    input  start_stop, load, preset_s,
    output state, remaining_s, bcd_digits,
    output tick_1s, alarm, alarm_blink
  );
endinterface

// File: rtl/countdown_timer_core.sv
// Runnable mm:ss countdown timer with pause, preset load and blinking alarm.
// Keeps the binary and BCD views of the remaining time in lock-step.
module countdown_timer_core #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int PRESET_S    = 150,
  parameter int MAX_S       = 3599,
  parameter int BLINK_DIV   = 25_000_000
) (
  input logic                  clk,
  input logic                  rst,
  countdown_timer_core_if.slave tmr
);

  localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Split 0..59 into tens/ones via reciprocal multiply.
  function automatic logic [7:0] split10(
    input logic [5:0] v
  );
    logic [15:0] p;
    logic [3:0]  t;
    p = 16'(v) * 16'd205;
    t = 4'(p >> 11);
    return {t, 4'(v - 6'(t) * 6'd10)};
  endfunction

  // Seconds to mm:ss BCD; 2185/2^17 is exact for 0..3599.
  function automatic logic [15:0] bin2bcd(
    input logic [11:0] s
  );
    logic [23:0] pm;
    logic [5:0]  m;
    logic [5:0]  sec;
    pm  = 24'(s) * 24'd2185;
    m   = 6'(pm >> 17);
    sec = 6'(s - 12'(m) * 12'd60);
    return {split10(m), split10(sec)};
  endfunction

  // Borrow-chain decrement of a non-zero mm:ss BCD value.
  function automatic logic [15:0] bcd_dec(
    input logic [15:0] b
  );
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = b;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  state_e         state_q, state_d;
  logic [11:0]    rem_q, rem_d;
  logic [15:0]    bcd_q, bcd_d;
  logic [11:0]    rld_q, rld_d;
  logic [15:0]    rbcd_q, rbcd_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           tick_q, tick_d;
  logic           alarm_q, alarm_d;
  logic           blink_q, blink_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;

  logic [11:0]    ld_val;
  logic [15:0]    ld_bcd;
  logic           term;

  assign ld_val = (tmr.preset_s > 12'(MAX_S)) ?
                  12'(MAX_S) : tmr.preset_s;
  assign ld_bcd = bin2bcd(ld_val);
  assign term   = (presc_q == PW'(CLK_FREQ_HZ - 1));

  // Next-state, counters and alarm blink.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    bcd_d   = bcd_q;
    rld_d   = rld_q;
    rbcd_d  = rbcd_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    alarm_d = 1'b0;
    blink_d = 1'b0;
    bcnt_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (tmr.load) begin
          rem_d   = ld_val;
          bcd_d   = ld_bcd;
          rld_d   = ld_val;
          rbcd_d  = ld_bcd;
          presc_d = '0;
        end else if (tmr.start_stop &&
                     rem_q != 12'd0) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_RUN: begin
        presc_d = term ? '0 : presc_q + PW'(1);
        if (term) begin
          rem_d  = rem_q - 12'd1;
          bcd_d  = bcd_dec(bcd_q);
          tick_d = 1'b1;
        end
        if (term && rem_q == 12'd1) begin
          state_d = S_DONE;
        end else if (tmr.start_stop) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (tmr.load) begin
          rem_d   = ld_val;
          bcd_d   = ld_bcd;
          rld_d   = ld_val;
          rbcd_d  = ld_bcd;
          presc_d = '0;
          state_d = S_IDLE;
        end else if (tmr.start_stop) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (tmr.load) begin
          rem_d   = ld_val;
          bcd_d   = ld_bcd;
          rld_d   = ld_val;
          rbcd_d  = ld_bcd;
          presc_d = '0;
          state_d = S_IDLE;
        end else if (tmr.start_stop) begin
          rem_d   = rld_q;
          bcd_d   = rbcd_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) begin
      alarm_d = 1'b1;
      if (state_q != S_DONE) begin
        blink_d = 1'b1;
      end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q + BW'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= 12'(PRESET_S);
      bcd_q   <= bin2bcd(12'(PRESET_S));
      rld_q   <= 12'(PRESET_S);
      rbcd_q  <= bin2bcd(12'(PRESET_S));
      presc_q <= '0;
      tick_q  <= 1'b0;
      alarm_q <= 1'b0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bcd_q   <= bcd_d;
      rld_q   <= rld_d;
      rbcd_q  <= rbcd_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      alarm_q <= alarm_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign tmr.state       = state_q;
  assign tmr.remaining_s = rem_q;
  assign tmr.bcd_digits  = bcd_q;
  assign tmr.tick_1s     = tick_q;
  assign tmr.alarm       = alarm_q;
  assign tmr.alarm_blink = blink_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Bench for countdown_timer_core: directed scenarios plus random
// command traffic, checked every cycle against a behavioural model.
module tb_countdown_timer_core;

  localparam int CF  = 10;
  localparam int PS  = 150;
  localparam int MX  = 3599;
  localparam int BD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  countdown_timer_core_if bus ();

  countdown_timer_core #(
    .CLK_FREQ_HZ (CF),
    .PRESET_S    (PS),
    .MAX_S       (MX),
    .BLINK_DIV   (BD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tmr (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model: state 0..3, seconds, reload, RUN cycles
  // since last second boundary, cycles spent in DONE
  int m_st, m_rem, m_rld, m_run, m_age, m_tick;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    int m, s;
    m = v / 60;
    s = v % 60;
    return {4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic m_load(input int v);
    m_rem = (v > MX) ? MX : v;
    m_rld = m_rem;
    m_run = 0;
  endtask

  task automatic model(input bit ss, input bit ld,
                       input int pv, input bit r);
    m_tick = 0;
    if (r) begin
      m_st = 0; m_rem = PS; m_rld = PS;
      m_run = 0; m_age = 0;
    end else begin
      case (m_st)
        0: if (ld) m_load(pv);
           else if (ss && m_rem != 0) begin
             m_st = 1; m_run = 0;
           end
        1: begin
          m_run++;
          if (m_run == CF) begin
            m_run = 0; m_rem--; m_tick = 1;
          end
          if (m_tick == 1 && m_rem == 0) begin
            m_st = 3; m_age = 0;
          end else if (ss) m_st = 2;
        end
        2: if (ld) begin
             m_load(pv); m_st = 0;
           end else if (ss) m_st = 1;
        default: begin
          m_age++;
          if (ld) begin
            m_load(pv); m_st = 0;
          end else if (ss) begin
            m_rem = m_rld; m_st = 0;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit ss, input bit ld,
                      input int pv, input bit r);
    bit blk;
    @(negedge clk);
    bus.start_stop = ss;
    bus.load       = ld;
    bus.preset_s   = 12'(pv);
    rst            = r;
    model(ss, ld, pv, r);
    @(posedge clk);
    #1;
    blk = (m_st == 3) && (((m_age / BD) % 2) == 0);
    chk("state", 32'(bus.state), 32'(m_st));
    chk("rem", 32'(bus.remaining_s), 32'(m_rem));
    chk("bcd", 32'(bus.bcd_digits),
        32'(ref_bcd(m_rem)));
    chk("tick", 32'(bus.tick_1s), 32'(m_tick));
    chk("alarm", 32'(bus.alarm), 32'(m_st == 3));
    chk("blink", 32'(bus.alarm_blink), 32'(blk));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    bus.start_stop = 1'b0;
    bus.load       = 1'b0;
    bus.preset_s   = '0;

    // reset state
    step(0, 0, 0, 1);
    chk("rst_bcd", 32'(bus.bcd_digits), 32'h0230);
    chk("rst_rem", 32'(bus.remaining_s), 32'd150);
    idle(2);

    // run 30 cycles: three ticks
    step(1, 0, 0, 0);
    idle(30);
    chk("run_rem", 32'(bus.remaining_s), 32'd147);
    chk("run_bcd", 32'(bus.bcd_digits), 32'h0227);

    // pause 5 after tick, hold, resume
    idle(4);
    step(1, 0, 0, 0);
    idle(100);
    chk("pause_rem", 32'(bus.remaining_s), 32'd147);
    step(1, 0, 0, 0);
    idle(5);
    chk("resume_tick", 32'(bus.tick_1s), 32'd1);
    chk("resume_rem", 32'(bus.remaining_s), 32'd146);

    // load 61 from PAUSE, run to DONE
    step(1, 0, 0, 0);
    step(0, 1, 61, 0);
    chk("ld61_bcd", 32'(bus.bcd_digits), 32'h0101);
    step(1, 0, 0, 0);
    idle(10);
    chk("t61a", 32'(bus.bcd_digits), 32'h0100);
    idle(10);
    chk("t61b", 32'(bus.bcd_digits), 32'h0059);
    idle(590);
    chk("done_st", 32'(bus.state), 32'd3);
    chk("done_alarm", 32'(bus.alarm), 32'd1);
    idle(BD);
    chk("blink_off", 32'(bus.alarm_blink), 32'd0);
    idle(BD);
    chk("blink_on", 32'(bus.alarm_blink), 32'd1);
    step(1, 0, 0, 0);
    chk("ack_rem", 32'(bus.remaining_s), 32'd61);
    chk("ack_alarm", 32'(bus.alarm), 32'd0);

    // clamp and zero load
    step(0, 1, 4000, 0);
    chk("clamp_rem", 32'(bus.remaining_s), 32'd3599);
    chk("clamp_bcd", 32'(bus.bcd_digits), 32'h5959);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    idle(15);
    chk("zero_st", 32'(bus.state), 32'd0);

    // load+start in PAUSE, ss on terminal count
    step(0, 1, 20, 0);
    step(1, 0, 0, 0);
    idle(3);
    step(1, 0, 0, 0);
    step(1, 1, 10, 0);
    chk("prio_st", 32'(bus.state), 32'd0);
    chk("prio_rem", 32'(bus.remaining_s), 32'd10);
    step(0, 1, 5, 0);
    step(1, 0, 0, 0);
    idle(9);
    step(1, 0, 0, 0);
    chk("tc_st", 32'(bus.state), 32'd2);
    chk("tc_rem", 32'(bus.remaining_s), 32'd4);

    // reset mid-RUN
    step(1, 0, 0, 0);
    idle(7);
    step(0, 0, 0, 1);
    chk("mrst_rem", 32'(bus.remaining_s), 32'd150);
    step(1, 0, 0, 0);
    idle(9);
    chk("mrst_notick", 32'(bus.tick_1s), 32'd0);
    idle(1);
    chk("mrst_tick", 32'(bus.tick_1s), 32'd1);

    // random command traffic
    for (int i = 0; i < 4000; i++) begin
      bit ss, ld, r;
      int pv;
      ss = ($urandom_range(0, 24) == 0);
      ld = ($urandom_range(0, 49) == 0);
      r  = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 3) == 0)
        pv = int'($urandom_range(0, 4095));
      else
        pv = int'($urandom_range(0, 4));
      step(ss, ld, pv, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
